// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic/arith ops plus iterative unsigned MUL/MULHU/DIVU/REMU.
// One op per valid/ready handshake; registered result with a one-cycle out_valid_o pulse.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(1);
    localparam logic [WIDTH-1:0] LP_W_VAL    = WIDTH'(WIDTH);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic                 r_out_valid;
    logic                 r_in_ready;

    logic [WIDTH-1:0]     w_alu;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_sub;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_iter_next;
    logic [WIDTH-1:0]     w_final;

    always_comb begin
        w_alu = '0;
        case (ctrl_i)
            4'd0:        w_alu = src1_i & src2_i;
            4'd1:        w_alu = src1_i | src2_i;
            4'd2:        w_alu = src1_i + src2_i;
            4'd3:        w_alu = src1_i - src2_i;
            4'd4:        w_alu = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            4'd5, 4'd13: w_alu = (src1_i < LP_W_VAL) ? (src2_i >> src1_i) : '0;
            4'd6:        w_alu = src2_i << (WIDTH / 2);
            4'd7:        w_alu = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default:     w_alu = '0;
        endcase
    end

    // Multiply: high half accumulates the multiplicand, low half holds the shrinking multiplier.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    // A zero divisor always "fits", yielding all-ones quotient and the dividend as remainder.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;
    assign w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    assign w_iter_next = r_op[1] ? w_div_next : w_mul_next;
    assign w_final     = r_op[0] ? w_iter_next[2*WIDTH-1:WIDTH] : w_iter_next[WIDTH-1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_op        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        if (ctrl_i[3:2] == 2'b10) begin
                            r_state    <= S_BUSY;
                            r_cnt      <= LP_CNT_LOAD;
                            r_acc      <= {{WIDTH{1'b0}}, src1_i};
                            r_opnd     <= src2_i;
                            r_op       <= ctrl_i[1:0];
                            r_in_ready <= 1'b0;
                        end else begin
                            r_result    <= w_alu;
                            r_zero      <= (w_alu == '0);
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_iter_next;
                    r_cnt <= r_cnt - LP_CNT_LAST;
                    if (r_cnt == LP_CNT_LAST) begin
                        r_state     <= S_IDLE;
                        r_result    <= w_final;
                        r_zero      <= (w_final == '0);
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign result_o    = r_result;
    assign zero_o      = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32: single-cycle ops, iterative ops,
// stall behaviour while busy, and asynchronous reset during a multiply.
module tb_alu_multicycle;

    logic        clk_i;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [3:0]  ctrl_i;
    logic        out_valid_o;
    logic [31:0] result_o;
    logic        zero_o;

    int total = 0;
    int bad   = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .ctrl_i      (ctrl_i),
        .out_valid_o (out_valid_o),
        .result_o    (result_o),
        .zero_o      (zero_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        src1_i     = '0;
        src2_i     = '0;
        ctrl_i     = '0;
        tick();
        tick();
        total++;
        if (result_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_result: got %h want %h", result_o, 32'h0);
        end
        total++;
        if (zero_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_zero: got %b want 1", zero_o);
        end
        total++;
        if (out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid_o);
        end
        rst_i = 1'b1;
        tick();
        total++;
        if (in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready_o);
        end
    endtask

    // ADD then SUB accepted on consecutive edges: consecutive pulses with fresh results.
    task automatic test_add_sub();
        in_valid_i = 1'b1;
        ctrl_i = 4'd2; src1_i = 32'h7FFF_FFFF; src2_i = 32'h1;
        tick();
        total++;
        if (out_valid_o !== 1'b1 || result_o !== 32'h8000_0000 || zero_o !== 1'b0) begin
            bad++;
            $display("FAIL add_overflow: got v=%b r=%h z=%b want v=1 r=80000000 z=0",
                     out_valid_o, result_o, zero_o);
        end
        ctrl_i = 4'd3; src1_i = 32'd5; src2_i = 32'd5;
        tick();
        total++;
        if (out_valid_o !== 1'b1 || result_o !== 32'h0 || zero_o !== 1'b1) begin
            bad++;
            $display("FAIL sub_zero: got v=%b r=%h z=%b want v=1 r=0 z=1",
                     out_valid_o, result_o, zero_o);
        end
        in_valid_i = 1'b0;
        tick();
        total++;
        if (out_valid_o !== 1'b0 || result_o !== 32'h0) begin
            bad++;
            $display("FAIL pulse_single: got v=%b r=%h want v=0 r=0", out_valid_o, result_o);
        end
    endtask

    task automatic test_single_ops();
        logic [3:0]  ops [12] = '{4'd7, 4'd4, 4'd5, 4'd13, 4'd0, 4'd1,
                                 4'd6, 4'd12, 4'd3, 4'd5, 4'd14, 4'd15};
        logic [31:0] as  [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd33, 32'd4,
                                 32'hF0F0, 32'hF0F0, 32'h5, 32'h9, 32'h0,
                                 32'd31, 32'h3, 32'h3};
        logic [31:0] bs  [12] = '{32'h1, 32'h1, 32'hF0, 32'hF0, 32'hFF00, 32'hFF00,
                                 32'h1234, 32'h9, 32'h1, 32'h8000_0000, 32'h4, 32'h4};
        logic [31:0] exp [12] = '{32'h1, 32'h0, 32'h0, 32'h0F, 32'hF000, 32'hFFF0,
                                 32'h1234_0000, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            in_valid_i = 1'b1;
            ctrl_i = ops[i]; src1_i = as[i]; src2_i = bs[i];
            tick();
            total++;
            if (out_valid_o !== 1'b1 || result_o !== exp[i] || zero_o !== (exp[i] == 32'h0)) begin
                bad++;
                $display("FAIL single_op%0d[%0d]: got v=%b r=%h z=%b want v=1 r=%h z=%b",
                         ops[i], i, out_valid_o, result_o, zero_o, exp[i], (exp[i] == 32'h0));
            end
        end
        in_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_multicycle();
        logic [3:0]  ops [8] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd10, 4'd11, 4'd8, 4'd9};
        logic [31:0] as  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                                32'h1234, 32'h1234, 32'h1_0000, 32'h1_0000};
        logic [31:0] bs  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
                                32'h0, 32'h0, 32'h1_0000, 32'h1_0000};
        logic [31:0] exp [8] = '{32'h1, 32'hFFFF_FFFE, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'h1234, 32'h0, 32'h1};
        int n;
        bit early;
        for (int i = 0; i < 8; i++) begin
            in_valid_i = 1'b1;
            ctrl_i = ops[i]; src1_i = as[i]; src2_i = bs[i];
            tick();
            in_valid_i = 1'b0;
            src1_i = 32'hDEAD_BEEF; src2_i = 32'h1;
            n = 0;
            early = 1'b0;
            while (in_ready_o !== 1'b1 && n < 40) begin
                if (out_valid_o !== 1'b0) early = 1'b1;
                tick();
                n++;
            end
            total++;
            if (n !== 32 || early) begin
                bad++;
                $display("FAIL multi_latency_op%0d[%0d]: got busy=%0d early=%b want busy=32 early=0",
                         ops[i], i, n, early);
            end
            total++;
            if (out_valid_o !== 1'b1 || result_o !== exp[i] || zero_o !== (exp[i] == 32'h0)) begin
                bad++;
                $display("FAIL multi_result_op%0d[%0d]: got v=%b r=%h z=%b want v=1 r=%h z=%b",
                         ops[i], i, out_valid_o, result_o, zero_o, exp[i], (exp[i] == 32'h0));
            end
            tick();
            total++;
            if (out_valid_o !== 1'b0 || result_o !== exp[i]) begin
                bad++;
                $display("FAIL multi_hold_op%0d[%0d]: got v=%b r=%h want v=0 r=%h",
                         ops[i], i, out_valid_o, result_o, exp[i]);
            end
        end
    endtask

    // Requester holds an ADD during DIVU; it must wait until ready returns.
    task automatic test_back_to_back();
        int n;
        in_valid_i = 1'b1;
        ctrl_i = 4'd10; src1_i = 32'd100; src2_i = 32'd7;
        tick();
        ctrl_i = 4'd2; src1_i = 32'd3; src2_i = 32'd4;
        n = 0;
        while (out_valid_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n !== 32 || result_o !== 32'd14 || in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_divu: got cycles=%0d r=%h rdy=%b want cycles=32 r=0000000e rdy=1",
                     n, result_o, in_ready_o);
        end
        tick();
        in_valid_i = 1'b0;
        total++;
        if (out_valid_o !== 1'b1 || result_o !== 32'd7 || zero_o !== 1'b0) begin
            bad++;
            $display("FAIL hold_add: got v=%b r=%h z=%b want v=1 r=00000007 z=0",
                     out_valid_o, result_o, zero_o);
        end
        tick();
        total++;
        if (out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL hold_add_pulse: got v=%b want 0", out_valid_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        int pulses;
        in_valid_i = 1'b1;
        ctrl_i = 4'd8; src1_i = 32'hFFFF_FFFF; src2_i = 32'h2;
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_i = 1'b0;
        #1;
        total++;
        if (result_o !== 32'h0 || zero_o !== 1'b1 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got r=%h z=%b v=%b want r=0 z=1 v=0",
                     result_o, zero_o, out_valid_o);
        end
        tick();
        rst_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid_o === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0 || in_ready_o !== 1'b1 || result_o !== 32'h0) begin
            bad++;
            $display("FAIL midreset_abort: got pulses=%0d rdy=%b r=%h want pulses=0 rdy=1 r=0",
                     pulses, in_ready_o, result_o);
        end
        in_valid_i = 1'b1;
        ctrl_i = 4'd0; src1_i = 32'hF0F0; src2_i = 32'hFF00;
        tick();
        in_valid_i = 1'b0;
        total++;
        if (out_valid_o !== 1'b1 || result_o !== 32'hF000 || zero_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_and: got v=%b r=%h z=%b want v=1 r=0000f000 z=0",
                     out_valid_o, result_o, zero_o);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_single_ops();
        test_multicycle();
        test_back_to_back();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
